rpn_calc_ctrl: RTL and testbench

Parametrised, clocked successor of the calculator key FSM. It is an RPN controller with a DEPTH-entry operand stack, multi-digit decimal entry and internal signed add/subtract with overflow detection. Store/load go to an external register file with synchronous read. It sits between the keypad decoder (key strobe + code) and the register file/display, exposing the top two stack entries as A and B.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_alu.sv | 33 +++
 rtl/rpn_calc_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rpn_calc_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, FSM state and entry-mode encodings for the RPN calculator controller.
package calc_pkg;

    localparam logic [3:0] KEY_ADD   = 4'hA;
    localparam logic [3:0] KEY_SUB   = 4'hB;
    localparam logic [3:0] KEY_STORE = 4'hC;
    localparam logic [3:0] KEY_LOAD  = 4'hD;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        LOAD_WAIT,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ENTRY,
        LIFT,
        REPLACE
    } mode_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational arithmetic for the calculator: signed add/sub and decimal digit append,
// each with its own overflow flag.
module calc_alu #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [3:0]   i_d,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_diff,
    output logic [W-1:0] o_dig,
    output logic         o_ovf_add,
    output logic         o_ovf_sub,
    output logic         o_ovf_dig
);

    logic [2*W-1:0] w_b_ext;
    logic [2*W-1:0] w_prod;

    assign o_sum  = i_a + i_b;
    assign o_diff = i_a - i_b;

    assign o_ovf_add = (i_a[W-1] == i_b[W-1]) && (o_sum[W-1] != i_a[W-1]);
    assign o_ovf_sub = (i_a[W-1] != i_b[W-1]) && (o_diff[W-1] != i_a[W-1]);

    assign w_b_ext = {{W{i_b[W-1]}}, i_b};
    assign w_prod  = (w_b_ext * (2*W)'(10)) + (2*W)'(i_d);
    assign o_dig   = w_prod[W-1:0];

    // The 2W result fits in W signed bits only if its top W+1 bits are a pure sign extension.
    assign o_ovf_dig = !((&w_prod[2*W-1:W-1]) || !(|w_prod[2*W-1:W-1]));

endmodule

// File: rtl/rpn_calc_ctrl.sv
// RPN calculator controller: operand stack, digit entry, add/sub and register-file store/load.
//
//   state     | meaning
//   IDLE      | waiting for a key, key_ready=1
//   EXEC      | applying the latched key to the stack (one cycle)
//   LOAD_WAIT | register-file read data arriving, written into B
//   ERROR     | stack frozen, only CLEAR has effect
module rpn_calc_ctrl
    import calc_pkg::*;
#(
    parameter int W      = 8,
    parameter int DEPTH  = 4,
    parameter int NREG   = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        tecla,
    output logic              key_ready,
    output logic [W-1:0]      A,
    output logic [W-1:0]      B,
    output logic [ADDR_W-1:0] regadress,
    output logic [W-1:0]      regstore,
    output logic              regwrite,
    input  logic [W-1:0]      regload,
    output logic              ok,
    output logic              err
);

    localparam logic [W-1:0] NREG_W = W'(NREG);

    state_t              r_state;
    state_t              w_state_nxt;
    mode_t               r_mode;
    mode_t               w_mode_nxt;
    logic [W-1:0]        r_stk     [DEPTH];
    logic [W-1:0]        w_stk_nxt [DEPTH];
    logic [3:0]          r_key;
    logic [ADDR_W-1:0]   r_regadress;
    logic [W-1:0]        r_regstore;

    logic [W-1:0]        w_a;
    logic [W-1:0]        w_b;
    logic [W-1:0]        w_sum;
    logic [W-1:0]        w_diff;
    logic [W-1:0]        w_dig;
    logic                w_ovf_add;
    logic                w_ovf_sub;
    logic                w_ovf_dig;
    logic                w_addr_ok;
    logic                w_addr_drv;
    logic                w_wr;

    assign w_b = r_stk[0];
    assign w_a = r_stk[1];

    calc_alu #(.W(W)) u_alu (
        .i_a       (w_a),
        .i_b       (w_b),
        .i_d       (r_key),
        .o_sum     (w_sum),
        .o_diff    (w_diff),
        .o_dig     (w_dig),
        .o_ovf_add (w_ovf_add),
        .o_ovf_sub (w_ovf_sub),
        .o_ovf_dig (w_ovf_dig)
    );

    assign w_addr_ok = !w_b[W-1] && (w_b < NREG_W);

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_stk_nxt   = r_stk;
        w_wr        = 1'b0;
        w_addr_drv  = 1'b0;

        case (r_state)
            IDLE: begin
                if (key_valid) begin
                    w_state_nxt = EXEC;
                end
            end

            EXEC: begin
                w_state_nxt = IDLE;
                if (is_digit(r_key)) begin
                    w_mode_nxt = ENTRY;
                    case (r_mode)
                        ENTRY: begin
                            if (w_ovf_dig) begin
                                w_state_nxt = ERROR;
                            end else begin
                                w_stk_nxt[0] = w_dig;
                            end
                        end
                        LIFT: begin
                            for (int i = DEPTH - 1; i >= 1; i--) w_stk_nxt[i] = r_stk[i-1];
                            w_stk_nxt[0] = W'(r_key);
                        end
                        default: w_stk_nxt[0] = W'(r_key);
                    endcase
                end else begin
                    case (r_key)
                        KEY_ADD, KEY_SUB, KEY_STORE: begin
                            if ((r_key == KEY_ADD && w_ovf_add) || (r_key == KEY_SUB && w_ovf_sub) ||
                                (r_key == KEY_STORE && !w_addr_ok)) begin
                                w_state_nxt = ERROR;
                            end else begin
                                for (int i = 1; i <= DEPTH - 2; i++) w_stk_nxt[i] = r_stk[i+1];
                                w_stk_nxt[DEPTH-1] = '0;
                                w_stk_nxt[0] = (r_key == KEY_ADD) ? w_sum :
                                               (r_key == KEY_SUB) ? w_diff : w_a;
                                w_mode_nxt = LIFT;
                                w_wr       = (r_key == KEY_STORE);
                                w_addr_drv = (r_key == KEY_STORE);
                            end
                        end
                        KEY_LOAD: begin
                            if (!w_addr_ok) begin
                                w_state_nxt = ERROR;
                            end else begin
                                w_state_nxt = LOAD_WAIT;
                                w_mode_nxt  = LIFT;
                                w_addr_drv  = 1'b1;
                            end
                        end
                        KEY_ENTER: begin
                            for (int i = DEPTH - 1; i >= 1; i--) w_stk_nxt[i] = r_stk[i-1];
                            w_mode_nxt = REPLACE;
                        end
                        default: begin
                            for (int i = 0; i < DEPTH; i++) w_stk_nxt[i] = '0;
                            w_mode_nxt = REPLACE;
                        end
                    endcase
                end
            end

            LOAD_WAIT: begin
                w_stk_nxt[0] = regload;
                w_state_nxt  = IDLE;
            end

            default: begin
                if (key_valid && tecla == KEY_CLEAR) begin
                    for (int i = 0; i < DEPTH; i++) w_stk_nxt[i] = '0;
                    w_mode_nxt  = REPLACE;
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mode      <= REPLACE;
            r_stk       <= '{default: '0};
            r_key       <= '0;
            r_regadress <= '0;
            r_regstore  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_stk       <= w_stk_nxt;
            r_regadress <= regadress;
            r_regstore  <= regstore;
            if (r_state == IDLE && key_valid) begin
                r_key <= tecla;
            end
        end
    end

    // Address and write data are driven during EXEC itself so the synchronous
    // register file sees them on the edge that ends EXEC.
    assign regadress = w_addr_drv ? w_b[ADDR_W-1:0] : r_regadress;
    assign regstore  = w_wr ? w_a : r_regstore;
    assign regwrite  = w_wr;

    assign key_ready = (r_state == IDLE) || (r_state == ERROR);
    assign A         = w_a;
    assign B         = w_b;
    assign ok        = (r_state != ERROR);
    assign err       = (r_state == ERROR);

endmodule

// File: tb/tb_rpn_calc_ctrl.sv
// Self-checking bench for rpn_calc_ctrl: directed key table, hand-written multi-cycle
// sequences and random keys checked against a queue-based stack model.
module tb_rpn_calc_ctrl;
    import calc_pkg::*;

    localparam int W      = 8;
    localparam int DEPTH  = 4;
    localparam int NREG   = 10;
    localparam int ADDR_W = 4;
    localparam int MAXV   = 127;
    localparam int MINV   = -128;
    localparam int M_ENTRY = 0, M_LIFT = 1, M_REPLACE = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              key_valid;
    logic [3:0]        tecla;
    logic              key_ready;
    logic [W-1:0]      A, B;
    logic [ADDR_W-1:0] regadress;
    logic [W-1:0]      regstore;
    logic              regwrite;
    logic [W-1:0]      regload;
    logic              ok, err;

    always #5 clk = ~clk;

    rpn_calc_ctrl #(.W(W), .DEPTH(DEPTH), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .tecla     (tecla),
        .key_ready (key_ready),
        .A         (A),
        .B         (B),
        .regadress (regadress),
        .regstore  (regstore),
        .regwrite  (regwrite),
        .regload   (regload),
        .ok        (ok),
        .err       (err)
    );

    // register file with synchronous read
    logic [W-1:0] mem [16];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            regload <= '0;
        end else begin
            if (regwrite) mem[regadress] <= regstore;
            regload <= mem[regadress];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // reference model: queue front is the top of the stack
    int m_q[$];
    int m_mode;
    bit m_err;
    int m_mem[NREG];
    int e_busy, e_nwr, e_waddr, e_wdata;

    task automatic m_clear();
        m_q = {};
        for (int i = 0; i < DEPTH; i++) m_q.push_back(0);
        m_mode = M_REPLACE;
        m_err  = 1'b0;
    endtask

    task automatic m_reset();
        m_clear();
        for (int i = 0; i < NREG; i++) m_mem[i] = 0;
    endtask

    task automatic m_push(input int v);
        m_q.push_front(v);
        void'(m_q.pop_back());
    endtask

    task automatic m_pop(input int r);
        void'(m_q.pop_front());
        m_q[0] = r;
        m_q.push_back(0);
    endtask

    task automatic model_step(input logic [3:0] k);
        int a, b, r;
        e_busy = 1; e_nwr = 0; e_waddr = 0; e_wdata = 0;
        if (m_err) begin
            e_busy = 0;
            if (k == KEY_CLEAR) m_clear();
            return;
        end
        a = m_q[1];
        b = m_q[0];
        if (k <= 4'd9) begin
            if (m_mode == M_ENTRY) begin
                r = b * 10 + int'(k);
                if (r > MAXV || r < MINV) m_err = 1'b1;
                else m_q[0] = r;
            end else if (m_mode == M_LIFT) begin
                m_push(int'(k));
            end else begin
                m_q[0] = int'(k);
            end
            m_mode = M_ENTRY;
        end else if (k == KEY_ADD || k == KEY_SUB) begin
            r = (k == KEY_ADD) ? a + b : a - b;
            if (r > MAXV || r < MINV) m_err = 1'b1;
            else begin m_pop(r); m_mode = M_LIFT; end
        end else if (k == KEY_ENTER) begin
            m_push(b);
            m_mode = M_REPLACE;
        end else if (k == KEY_STORE || k == KEY_LOAD) begin
            if (b < 0 || b >= NREG) m_err = 1'b1;
            else if (k == KEY_STORE) begin
                e_nwr = 1; e_waddr = b; e_wdata = a;
                m_mem[b] = a;
                m_pop(a);
                m_mode = M_LIFT;
            end else begin
                e_busy = 2;
                m_q[0] = m_mem[b];
                m_mode = M_LIFT;
            end
        end else begin
            m_clear();
        end
    endtask

    int busy, n_wr, wr_addr, wr_data;

    task automatic press(input logic [3:0] k);
        int guard;
        guard = 0;
        while (!key_ready && guard < 20) begin @(negedge clk); guard++; end
        key_valid = 1'b1;
        tecla     = k;
        @(negedge clk);
        key_valid = 1'b0;
        busy = 0; n_wr = 0; wr_addr = 0; wr_data = 0; guard = 0;
        while (!key_ready && guard < 20) begin
            if (regwrite) begin
                n_wr++;
                wr_addr = int'(regadress);
                wr_data = int'($signed(regstore));
            end
            busy++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("ready_timeout", int'(key_ready), 1);
        model_step(k);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_A"},         int'($signed(A)), 0);
        check({tag, "_B"},         int'($signed(B)), 0);
        check({tag, "_key_ready"}, int'(key_ready), 1);
        check({tag, "_regwrite"},  int'(regwrite), 0);
        check({tag, "_regadress"}, int'(regadress), 0);
        check({tag, "_regstore"},  int'(regstore), 0);
        check({tag, "_ok"},        int'(ok), 1);
        check({tag, "_err"},       int'(err), 0);
    endtask

    function automatic logic [3:0] rand_key();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55) return 4'($urandom_range(0, 9));
        if (r < 65) return KEY_ADD;
        if (r < 73) return KEY_SUB;
        if (r < 80) return KEY_ENTER;
        if (r < 86) return KEY_STORE;
        if (r < 92) return KEY_LOAD;
        return KEY_CLEAR;
    endfunction

    typedef struct {
        logic [3:0] key;
        int         exp_a;
        int         exp_b;
        bit         exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] k, input int a, input int b, input bit e);
        vec_t v;
        v.key = k; v.exp_a = a; v.exp_b = b; v.exp_err = e;
        tbl.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [3:0] k;

        reset = 1'b1; key_valid = 1'b0; tecla = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // digit entry, digit overflow, clear
        add(4'd1, 0, 1, 0);   add(4'd2, 0, 12, 0);  add(4'd3, 0, 123, 0);
        add(4'd4, 0, 123, 1); add(KEY_CLEAR, 0, 0, 0);
        // 100 ENTER 27 ADD, then 1 ADD overflows at 127+1
        add(4'd1, 0, 1, 0);   add(4'd0, 0, 10, 0);  add(4'd0, 0, 100, 0);
        add(KEY_ENTER, 100, 100, 0); add(4'd2, 100, 2, 0); add(4'd7, 100, 27, 0);
        add(KEY_ADD, 0, 127, 0); add(4'd1, 127, 1, 0); add(KEY_ADD, 127, 1, 1);
        add(4'd5, 127, 1, 1); add(KEY_CLEAR, 0, 0, 0);
        // 5 ENTER 9 SUB -> -4
        add(4'd5, 0, 5, 0);   add(KEY_ENTER, 5, 5, 0); add(4'd9, 5, 9, 0);
        add(KEY_SUB, 0, -4, 0); add(KEY_CLEAR, 0, 0, 0);
        // stack fill with discard of the bottom entry, then collapse
        add(4'd1, 0, 1, 0);   add(KEY_ENTER, 1, 1, 0); add(4'd2, 1, 2, 0);
        add(KEY_ENTER, 2, 2, 0); add(4'd3, 2, 3, 0); add(KEY_ENTER, 3, 3, 0);
        add(4'd4, 3, 4, 0);   add(KEY_ENTER, 4, 4, 0); add(4'd5, 4, 5, 0);
        add(KEY_ADD, 3, 9, 0); add(KEY_ADD, 2, 12, 0); add(KEY_ADD, 0, 14, 0);
        add(KEY_ADD, 0, 14, 0); add(KEY_CLEAR, 0, 0, 0);
        // 0-100 = -100, then -100-100 overflows
        add(4'd1, 0, 1, 0);   add(4'd0, 0, 10, 0);  add(4'd0, 0, 100, 0);
        add(KEY_SUB, 0, -100, 0); add(4'd1, -100, 1, 0); add(4'd0, -100, 10, 0);
        add(4'd0, -100, 100, 0); add(KEY_SUB, -100, 100, 1); add(KEY_CLEAR, 0, 0, 0);

        foreach (tbl[i]) begin
            press(tbl[i].key);
            check($sformatf("tbl%0d_A", i),   int'($signed(A)), tbl[i].exp_a);
            check($sformatf("tbl%0d_B", i),   int'($signed(B)), tbl[i].exp_b);
            check($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].exp_err));
            check($sformatf("tbl%0d_ok", i),  int'(ok), int'(!tbl[i].exp_err));
        end

        // 42 ENTER 3 STORE: one-cycle write pulse
        press(4'd4); press(4'd2); press(KEY_ENTER); press(4'd3); press(KEY_STORE);
        check("store_nwr",  n_wr, 1);
        check("store_addr", wr_addr, 3);
        check("store_data", wr_data, 42);
        check("store_B",    int'($signed(B)), 42);
        check("store_busy", busy, 1);

        // 7 ENTER 10 STORE: address out of range, no write
        press(4'd7); press(KEY_ENTER); press(4'd1); press(4'd0); press(KEY_STORE);
        check("store_bad_err", int'(err), 1);
        check("store_bad_nwr", n_wr, 0);
        press(KEY_CLEAR);

        // store 0x55 at 3, then 3 LOAD with key_valid held through EXEC/LOAD_WAIT
        press(4'd8); press(4'd5); press(KEY_ENTER); press(4'd3); press(KEY_STORE);
        press(4'd3);
        key_valid = 1'b1; tecla = KEY_LOAD;
        @(negedge clk);
        tecla = 4'd9;
        busy = 0; guard = 0;
        while (!key_ready && guard < 20) begin busy++; @(negedge clk); guard++; end
        key_valid = 1'b0;
        if (guard >= 20) check("load_timeout", int'(key_ready), 1);
        model_step(KEY_LOAD);
        check("load_busy", busy, 2);
        check("load_B",    int'(B), 8'h55);
        check("load_A",    int'(A), 8'h55);
        check("load_err",  int'(err), 0);

        // reset during LOAD_WAIT
        press(KEY_CLEAR); press(4'd3);
        key_valid = 1'b1; tecla = KEY_LOAD;
        @(negedge clk);
        key_valid = 1'b0;
        check("exec_regadress", int'(regadress), 3);
        @(negedge clk);
        check("loadwait_ready", int'(key_ready), 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_loadwait");
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(negedge clk);

        // reset during the store pulse drops regwrite at once
        press(4'd5); press(KEY_ENTER); press(4'd2);
        key_valid = 1'b1; tecla = KEY_STORE;
        @(negedge clk);
        key_valid = 1'b0;
        check("pulse_regwrite",  int'(regwrite), 1);
        check("pulse_regadress", int'(regadress), 2);
        check("pulse_regstore",  int'(regstore), 5);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_store");
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(negedge clk);

        // random keys against the model
        for (int n = 0; n < 400; n++) begin
            k = rand_key();
            press(k);
            check($sformatf("rnd%0d_k%0d_A", n, k),   int'($signed(A)), m_q[1]);
            check($sformatf("rnd%0d_k%0d_B", n, k),   int'($signed(B)), m_q[0]);
            check($sformatf("rnd%0d_k%0d_err", n, k), int'(err), int'(m_err));
            check($sformatf("rnd%0d_k%0d_busy", n, k), busy, e_busy);
            check($sformatf("rnd%0d_k%0d_nwr", n, k), n_wr, e_nwr);
            if (e_nwr == 1) begin
                check($sformatf("rnd%0d_waddr", n), wr_addr, e_waddr);
                check($sformatf("rnd%0d_wdata", n), wr_data, e_wdata);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
